// File: rtl/layer0_patch_feeder_pkg.sv
// Shared types and sizing for the layer-0 patch feeder.
package layer0_patch_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } feeder_state_t;

  localparam int MACS_DEFAULT   = 27;
  localparam int NUM_OC_DEFAULT = 32;
  localparam int WMEM_DEPTH     = NUM_OC_DEFAULT * MACS_DEFAULT;

endpackage

// File: rtl/layer0_wmem.sv
// Byte-write weight RAM with combinational read; no reset, contents survive only until reloaded.
module layer0_wmem #(
  parameter int DEPTH  = 864,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Addresses past the end read as zero so stray engine indices cannot alias.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/layer0_patch_feeder.sv
// Parent-side driver for the layer-0 MAC engine: one patch in, one int8 result per output channel out.
module layer0_patch_feeder
  import layer0_patch_feeder_pkg::*;
#(
  parameter int MACS   = MACS_DEFAULT,
  parameter int NUM_OC = NUM_OC_DEFAULT,
  parameter int OC_W   = $clog2(NUM_OC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wload_valid,
  output logic              wload_ready,
  input  logic [7:0]        wload_data,
  input  logic              bias_we,
  input  logic [OC_W-1:0]   bias_addr,
  input  logic [31:0]       bias_data,
  input  logic [15:0]       scale_in,
  input  logic              patch_valid,
  output logic              patch_ready,
  input  logic [8*MACS-1:0] patch_data,
  output logic              eng_start,
  input  logic [4:0]        eng_mac_index,
  output logic [7:0]        eng_act,
  output logic [7:0]        eng_w,
  output logic [31:0]       eng_bias,
  output logic [15:0]       eng_scale,
  input  logic              eng_done,
  input  logic [7:0]        eng_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [OC_W-1:0]   out_oc,
  output logic              out_last
);

  localparam int DEPTH  = NUM_OC * MACS;
  localparam int ADDR_W = $clog2(DEPTH);

  feeder_state_t     state, state_nxt;
  logic [OC_W-1:0]   oc;
  logic [ADDR_W-1:0] wcnt;
  logic              weights_loaded;
  logic [8*MACS-1:0] patch_reg;
  logic [31:0]       bmem [NUM_OC];
  logic              patch_fire, wload_fire, idx_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        w_rd;

  assign patch_ready = (state == S_IDLE) && weights_loaded && (wcnt == '0);
  assign patch_fire  = patch_valid && patch_ready;
  assign wload_ready = (state == S_IDLE) && !patch_fire;
  assign wload_fire  = wload_valid && wload_ready;

  assign idx_ok    = 32'(eng_mac_index) < MACS;
  assign rd_addr   = ADDR_W'(32'(oc) * MACS + 32'(eng_mac_index));
  assign eng_w     = idx_ok ? w_rd : 8'h00;
  assign eng_bias  = bmem[oc];
  assign eng_scale = scale_in;

  layer0_wmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wmem (
    .clk   (clk),
    .we    (wload_fire),
    .waddr (wcnt),
    .wdata (wload_data),
    .raddr (rd_addr),
    .rdata (w_rd)
  );

  always_comb begin
    eng_act = 8'h00;
    for (int k = 0; k < MACS; k++) begin
      if (eng_mac_index == 5'(k)) eng_act = patch_reg[8*k +: 8];
    end
  end

  // A new load invalidates the weight set until its final byte lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt           <= '0;
      weights_loaded <= 1'b0;
    end else if (wload_fire) begin
      if (wcnt == ADDR_W'(DEPTH - 1)) begin
        wcnt           <= '0;
        weights_loaded <= 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '0) weights_loaded <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bias_we && state == S_IDLE) bmem[bias_addr] <= bias_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  if (patch_fire) state_nxt = S_START;
      S_START: begin
        eng_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  if (eng_done) state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = out_last ? S_IDLE : S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patch_reg <= '0;
      oc        <= '0;
      out_data  <= 8'h00;
      out_oc    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && patch_fire) begin
        patch_reg <= patch_data;
        oc        <= '0;
      end
      if (state == S_WAIT && eng_done) begin
        out_data <= eng_result;
        out_oc   <= oc;
        out_last <= (oc == OC_W'(NUM_OC - 1));
      end
      if (state == S_OUT && out_ready && !out_last) oc <= oc + 1'b1;
    end
  end

endmodule

// File: tb/tb_layer0_patch_feeder.sv
// Randomized scoreboard bench for layer0_patch_feeder with a behavioural engine stub.
module tb_layer0_patch_feeder;
  import layer0_patch_feeder_pkg::*;

  localparam int MACS   = 27;
  localparam int NUM_OC = 32;
  localparam int DEPTH  = NUM_OC * MACS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wload_valid, wload_ready;
  logic [7:0]        wload_data;
  logic              bias_we;
  logic [4:0]        bias_addr;
  logic [31:0]       bias_data;
  logic [15:0]       scale_in;
  logic              patch_valid, patch_ready;
  logic [8*MACS-1:0] patch_data;
  logic              eng_start;
  logic [4:0]        eng_mac_index;
  logic [7:0]        eng_act, eng_w;
  logic [31:0]       eng_bias;
  logic [15:0]       eng_scale;
  logic              eng_done;
  logic [7:0]        eng_result;
  logic              out_valid, out_ready;
  logic [7:0]        out_data;
  logic [4:0]        out_oc;
  logic              out_last;

  layer0_patch_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .wload_valid(wload_valid), .wload_ready(wload_ready), .wload_data(wload_data),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
    .scale_in(scale_in),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_data(patch_data),
    .eng_start(eng_start), .eng_mac_index(eng_mac_index), .eng_act(eng_act), .eng_w(eng_w),
    .eng_bias(eng_bias), .eng_scale(eng_scale), .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_oc(out_oc),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int oc;
    int last;
  } exp_t;

  exp_t sb[$];
  byte  w_m [DEPTH];
  byte  patch_m [MACS];
  int   bias_m [NUM_OC];
  int   checks = 0;
  int   failures = 0;
  int   run_oc = 0;
  int   cur_oc = 0;
  bit   stub_busy = 1'b0;
  int   stall_oc = 0;
  int   stall_left = 0;

  task automatic check_output(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Expected channel result straight from the arithmetic definition: saturated dot product plus bias.
  function automatic int ref_out(int c);
    longint acc = longint'(bias_m[c]);
    for (int k = 0; k < MACS; k++) acc += longint'(patch_m[k]) * longint'(w_m[c*MACS + k]);
    if (acc > 127) return 127;
    if (acc < -128) return -128;
    return int'(acc);
  endfunction

  task automatic load_weights(input int first, input int last);
    for (int i = first; i < last; i++) begin
      int guard = 0;
      @(negedge clk);
      wload_valid = 1'b1;
      wload_data  = w_m[i];
      #1;
      while (!wload_ready && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
    end
    @(negedge clk);
    wload_valid = 1'b0;
  endtask

  task automatic write_bias(input int addr, input int value, input bit takes_effect);
    @(negedge clk);
    bias_we   = 1'b1;
    bias_addr = 5'(addr);
    bias_data = 32'(value);
    @(negedge clk);
    bias_we = 1'b0;
    if (takes_effect) bias_m[addr] = value;
  endtask

  task automatic apply_stimulus(input bit with_wload);
    int guard = 0;
    @(negedge clk);
    for (int k = 0; k < MACS; k++) patch_data[8*k +: 8] = patch_m[k];
    patch_valid = 1'b1;
    if (with_wload) begin
      wload_valid = 1'b1;
      wload_data  = 8'h5a;
    end
    #1;
    while (!patch_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_output("patch_accept", patch_ready, 1);
    if (with_wload) check_output("wload_ready_vs_patch", wload_ready, 0);
    if (patch_ready) begin
      run_oc = 0;
      for (int c = 0; c < NUM_OC; c++) sb.push_back('{ref_out(c), c, (c == NUM_OC-1) ? 1 : 0});
    end
    @(negedge clk);
    patch_valid = 1'b0;
    wload_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || out_valid || stub_busy) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_output("drain_in_time", (guard < 4000) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_run(input int c);
    int guard = 0;
    while (!(stub_busy && cur_oc == c) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_output("reached_run", cur_oc, c);
  endtask

  // Engine stand-in: walks mac_index 0..26, accumulates the served operands, returns a saturated sum.
  task automatic run_engine();
    longint acc = 0;
    int lat;
    stub_busy = 1'b1;
    cur_oc = run_oc;
    run_oc++;
    for (int k = 0; k < MACS; k++) begin
      eng_mac_index = 5'(k);
      @(negedge clk);
      if (!rst_n) begin stub_busy = 1'b0; return; end
      check_output("eng_act", longint'($signed(eng_act)), longint'(patch_m[k]));
      check_output("eng_w", longint'($signed(eng_w)), longint'(w_m[cur_oc*MACS + k]));
      acc += longint'($signed(eng_act)) * longint'($signed(eng_w));
    end
    eng_mac_index = 5'(MACS + int'($urandom_range(0, 4)));
    @(negedge clk);
    if (!rst_n) begin stub_busy = 1'b0; return; end
    check_output("eng_act_oor", eng_act, 0);
    check_output("eng_w_oor", eng_w, 0);
    check_output("eng_bias", longint'($signed(eng_bias)), bias_m[cur_oc]);
    check_output("eng_scale", eng_scale, scale_in);
    acc += longint'($signed(eng_bias));
    lat = int'($urandom_range(0, 3));
    repeat (lat) begin
      @(negedge clk);
      if (!rst_n) begin stub_busy = 1'b0; return; end
    end
    eng_result = (acc > 127) ? 8'sd127 : (acc < -128) ? -8'sd128 : 8'(acc);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    stub_busy = 1'b0;
  endtask

  initial begin : engine_stub
    eng_done = 1'b0;
    eng_result = 8'h00;
    eng_mac_index = 5'd0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start) run_engine();
    end
  end

  // Monitor: owns out_ready, pops the scoreboard on each accepted beat, checks holds during stalls.
  initial begin : monitor
    bit held = 1'b0;
    bit pr_next = 1'b0;
    int held_data = 0;
    int held_oc = 0;
    bit rdy;
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        pr_next = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (pr_next) begin
          check_output("patch_ready_after_last", patch_ready, 1);
          pr_next = 1'b0;
        end
        if (held) begin
          check_output("stall_valid", out_valid, 1);
          check_output("stall_data", longint'($signed(out_data)), held_data);
          check_output("stall_oc", out_oc, held_oc);
          check_output("stall_no_start", eng_start, 0);
        end
        if (stall_left > 0 && out_valid && int'(out_oc) == stall_oc) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        out_ready = rdy;
        held = 1'b0;
        if (out_valid) begin
          if (rdy) begin
            if (sb.size() == 0) begin
              check_output("unexpected_beat", 1, 0);
            end else begin
              e = sb.pop_front();
              check_output("out_data", longint'($signed(out_data)), e.data);
              check_output("out_oc", out_oc, e.oc);
              check_output("out_last", out_last, e.last);
            end
            if (out_last) pr_next = 1'b1;
          end else begin
            held = 1'b1;
            held_data = int'($signed(out_data));
            held_oc = int'(out_oc);
          end
        end
      end
    end
  end

  initial begin : main
    rst_n = 1'b0;
    patch_valid = 1'b0;
    patch_data = '0;
    wload_valid = 1'b0;
    wload_data = 8'h00;
    bias_we = 1'b0;
    bias_addr = 5'd0;
    bias_data = 32'd0;
    scale_in = 16'h8000;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_patch_ready", patch_ready, 0);
    check_output("rst_wload_ready", wload_ready, 1);
    check_output("rst_eng_start", eng_start, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_oc", out_oc, 0);
    check_output("rst_out_last", out_last, 0);
    rst_n = 1'b1;

    @(negedge clk);
    patch_valid = 1'b1;
    #1 check_output("patch_ready_unloaded", patch_ready, 0);
    patch_valid = 1'b0;

    $display("[TB] uniform weights=1, patch=2, bias=0");
    for (int i = 0; i < DEPTH; i++) w_m[i] = 8'sd1;
    for (int k = 0; k < MACS; k++) patch_m[k] = 8'sd2;
    for (int c = 0; c < NUM_OC; c++) write_bias(c, 0, 1'b1);
    load_weights(0, 100);
    @(negedge clk);
    patch_valid = 1'b1;
    #1 check_output("patch_ready_midload", patch_ready, 0);
    patch_valid = 1'b0;
    load_weights(100, DEPTH);
    apply_stimulus(1'b0);
    wait_drain();

    $display("[TB] one-hot weights, patch byte k = k");
    for (int c = 0; c < NUM_OC; c++)
      for (int k = 0; k < MACS; k++) w_m[c*MACS + k] = (k == c % MACS) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < MACS; k++) patch_m[k] = byte'(k);
    load_weights(0, DEPTH);
    apply_stimulus(1'b0);
    wait_drain();

    $display("[TB] bias write while busy, then while idle");
    apply_stimulus(1'b0);
    wait_run(1);
    write_bias(3, -1000, 1'b0);
    wait_drain();
    write_bias(3, -1000, 1'b1);
    apply_stimulus(1'b1);
    wait_drain();

    $display("[TB] random data with output stall on channel 5");
    for (int i = 0; i < DEPTH; i++) w_m[i] = byte'($urandom_range(0, 255));
    for (int k = 0; k < MACS; k++) patch_m[k] = byte'($urandom_range(0, 255));
    for (int c = 0; c < NUM_OC; c++) write_bias(c, int'($urandom_range(0, 4000)) - 2000, 1'b1);
    load_weights(0, DEPTH);
    stall_oc = 5;
    stall_left = 20;
    apply_stimulus(1'b0);
    wait_drain();
    check_output("stall_consumed", stall_left, 0);

    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < MACS; k++) patch_m[k] = byte'($urandom_range(0, 31)) - 8'sd16;
      apply_stimulus(1'b0);
      wait_drain();
    end

    $display("[TB] reset during channel 10");
    apply_stimulus(1'b0);
    wait_run(10);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_patch_ready", patch_ready, 0);
    check_output("midrst_out_oc", out_oc, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    patch_valid = 1'b1;
    #1 check_output("postrst_patch_ready", patch_ready, 0);
    patch_valid = 1'b0;
    load_weights(0, DEPTH);
    apply_stimulus(1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
